// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared types and helpers for the serial subtractor
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Chunk counter width: clog2 of the chunk count, never narrower than one bit.
    function automatic int cnt_width(input int nch);
        return (nch <= 2) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/sub_chunk.sv
// rtl/sub_chunk.sv - combinational CHUNK-bit ripple of full-subtractor cells
module sub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] diff,
    output logic             bout,
    output logic             msb_bin
);

    logic [CHUNK:0] borrow;

    always_comb begin
        borrow    = '0;
        diff      = '0;
        borrow[0] = bin;
        for (int i = 0; i < CHUNK; i++) begin
            diff[i]       = a[i] ^ b[i] ^ borrow[i];
            borrow[i+1]   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
        end
    end

    assign bout    = borrow[CHUNK];
    assign msb_bin = borrow[CHUNK-1];

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - multi-cycle a - b - bin, CHUNK bits per clock
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = cnt_width(NCH);
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("serial_subtractor: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    sub_state_t       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic [WIDTH-1:0] diff_next;
    logic             borrow;
    logic [CW-1:0]    count;
    logic             ovf_r;

    logic [CHUNK-1:0] c_diff;
    logic             c_bout;
    logic             c_msb_bin;

    sub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a       (a_sr[CHUNK-1:0]),
        .b       (b_sr[CHUNK-1:0]),
        .bin     (borrow),
        .diff    (c_diff),
        .bout    (c_bout),
        .msb_bin (c_msb_bin)
    );

    // Results enter at the top so the first (least significant) chunk ends at bit 0.
    generate
        if (CHUNK == WIDTH) begin : g_single
            assign diff_next = c_diff;
        end else begin : g_multi
            assign diff_next = {c_diff, diff_sr[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            borrow  <= 1'b0;
            count   <= '0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= bin;
                        count  <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sr    <= a_sr >> CHUNK;
                    b_sr    <= b_sr >> CHUNK;
                    diff_sr <= diff_next;
                    borrow  <= c_bout;
                    count   <= count + CW'(1);
                    if (count == LAST) begin
                        // Signed overflow: borrow into the sign bit differs from borrow out of it.
                        ovf_r <= c_msb_bin ^ c_bout;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign diff      = diff_sr;
    assign bout      = borrow;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and exhaustive checks of serial_subtractor
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    logic rst_g;
    bit   done [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    initial begin
        rst_g = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_g = 1'b1;
    end

    generate
        for (genvar k = 0; k < 4; k++) begin : g
            localparam int W   = (k == 0) ? 16 : 4;
            localparam int C   = (k == 0) ? 4 : (k == 1) ? 1 : (k == 2) ? 2 : 4;
            localparam int NCH = W / C;

            logic         rst_n, in_valid, in_ready, bin, out_valid, out_ready, bout, ovf;
            logic [W-1:0] a, b, diff;

            serial_subtractor #(.WIDTH(W), .CHUNK(C)) dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid),
                .in_ready  (in_ready),
                .a         (a),
                .b         (b),
                .bin       (bin),
                .out_valid (out_valid),
                .out_ready (out_ready),
                .diff      (diff),
                .bout      (bout),
                .ovf       (ovf)
            );

            // Reference model: arithmetic result per accepted operation, plus
            // the handshake timing (busy from accept until the result is taken).
            bit           busy     = 1'b0;
            int           acc_cyc  = 0;
            int           resp_cnt = 0;
            logic [W-1:0] q_diff [$];
            bit           q_bout [$];
            bit           q_ovf  [$];
            logic [W:0]   t;
            int           sa, sb, r;
            bit           exp_ov;

            always @(negedge clk) begin
                if (!rst_n) begin
                    busy = 1'b0;
                    q_diff.delete();
                    q_bout.delete();
                    q_ovf.delete();
                    chk("rst_out_valid", out_valid, 0);
                    chk("rst_in_ready", in_ready, 1);
                    chk("rst_diff", diff, 0);
                end else begin
                    exp_ov = busy && (cyc - acc_cyc >= NCH);
                    chk("in_ready", in_ready, !busy);
                    chk("out_valid", out_valid, exp_ov);
                    if (exp_ov && out_valid && q_diff.size() > 0) begin
                        chk("diff", diff, q_diff[0]);
                        chk("bout", bout, q_bout[0]);
                        chk("ovf", ovf, q_ovf[0]);
                    end
                    if (!busy && in_valid) begin
                        t  = {1'b0, a} - {1'b0, b} - bin;
                        sa = $signed(a);
                        sb = $signed(b);
                        r  = sa - sb - int'(bin);
                        q_diff.push_back(t[W-1:0]);
                        q_bout.push_back(t[W]);
                        q_ovf.push_back((r < -(2 ** (W - 1))) || (r > (2 ** (W - 1)) - 1));
                        busy    = 1'b1;
                        acc_cyc = cyc + 1;
                    end else if (exp_ov && out_ready) begin
                        if (q_diff.size() > 0) begin
                            void'(q_diff.pop_front());
                            void'(q_bout.pop_front());
                            void'(q_ovf.pop_front());
                        end
                        busy = 1'b0;
                        resp_cnt++;
                    end
                end
            end

            task automatic wait_accept();
                int n;
                n = 0;
                while (!in_ready && n < 100) begin
                    @(posedge clk); #1;
                    n++;
                end
                if (!in_ready) chk("accept_timeout", 0, 1);
                @(posedge clk); #1;
            endtask

            task automatic wait_result(output int n);
                n = 0;
                while (!out_valid && n < 60) begin
                    chk("busy_in_ready", in_ready, 0);
                    @(posedge clk); #1;
                    n++;
                end
                if (!out_valid) chk("result_timeout", 0, 1);
            endtask

            if (k == 0) begin : dir
                task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in,
                                     input logic [W-1:0] ed, input logic eb, input logic eo);
                    int n;
                    a = av; b = bv; bin = bv_in; in_valid = 1'b1; out_ready = 1'b1;
                    wait_accept();
                    in_valid = 1'b0;
                    wait_result(n);
                    chk("lit_latency", n, 4);
                    chk("lit_diff", diff, ed);
                    chk("lit_bout", bout, eb);
                    chk("lit_ovf", ovf, eo);
                    @(posedge clk); #1;
                endtask

                initial begin
                    int n;
                    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
                    @(posedge clk); #1;
                    chk("lit_rst_in_ready", in_ready, 1);
                    chk("lit_rst_out_valid", out_valid, 0);
                    chk("lit_rst_diff", diff, 0);
                    chk("lit_rst_bout", bout, 0);
                    chk("lit_rst_ovf", ovf, 0);
                    @(posedge clk); #1 rst_n = 1'b1;

                    do_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
                    do_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
                    do_op(16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0);
                    do_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
                    do_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

                    // Backpressure: result held while new operands wait.
                    a = 16'h00F0; b = 16'h0010; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
                    wait_accept();
                    in_valid = 1'b0;
                    wait_result(n);
                    a = 16'h1111; b = 16'h0001; in_valid = 1'b1;
                    for (int i = 0; i < 5; i++) begin
                        chk("bp_diff", diff, 16'h00E0);
                        chk("bp_bout", bout, 0);
                        chk("bp_in_ready", in_ready, 0);
                        chk("bp_out_valid", out_valid, 1);
                        @(posedge clk); #1;
                    end
                    out_ready = 1'b1;
                    @(posedge clk); #1;
                    chk("bp_ready_after_hs", in_ready, 1);
                    @(posedge clk); #1;
                    chk("bp_accepted", in_ready, 0);
                    in_valid = 1'b0;
                    wait_result(n);
                    chk("bp_second_diff", diff, 16'h1110);
                    @(posedge clk); #1;

                    // Reset two cycles into RUN discards the operation.
                    a = 16'hABCD; b = 16'h0001; in_valid = 1'b1;
                    wait_accept();
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                    @(posedge clk); #1;
                    rst_n = 1'b0;
                    #1;
                    chk("lit_midrst_out_valid", out_valid, 0);
                    chk("lit_midrst_diff", diff, 0);
                    chk("lit_midrst_in_ready", in_ready, 1);
                    @(posedge clk); #1 rst_n = 1'b1;
                    do_op(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0);
                    done[k] = 1'b1;
                end
            end else begin : exh
                assign rst_n = rst_g;

                initial begin
                    out_ready = 1'b0;
                    while (!done[k]) begin
                        @(posedge clk); #1;
                        out_ready = ($urandom_range(0, 3) != 0);
                    end
                end

                initial begin
                    int n;
                    in_valid = 1'b0; a = '0; b = '0; bin = 1'b0;
                    n = 0;
                    while (rst_g !== 1'b1 && n < 20) begin
                        @(posedge clk); #1;
                        n++;
                    end
                    for (int v = 0; v < 512; v++) begin
                        {bin, a, b} = v[8:0];
                        in_valid = 1'b1;
                        wait_accept();
                        in_valid = 1'b0;
                    end
                    n = 0;
                    while (resp_cnt < 512 && n < 2000) begin
                        @(posedge clk); #1;
                        n++;
                    end
                    chk("exh_count", resp_cnt, 512);
                    done[k] = 1'b1;
                end
            end
        end
    endgenerate

    initial begin
        int n;
        n = 0;
        while (!(done[0] && done[1] && done[2] && done[3]) && n < 60000) begin
            @(posedge clk);
            n++;
        end
        if (!(done[0] && done[1] && done[2] && done[3])) chk("global_timeout", 0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
